// File: rtl/mips_pkg.sv
// Shared constants and types for the writeback stage and its load alignment helper.
// Defaults for datapath/register-index widths, load size encodings, skid states.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_e;

endpackage

// File: rtl/load_align.sv
// Little-endian lane select and sign/zero extension of a raw load word.
// Purely combinational; no backpressure.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] load_data,
  input  logic [1:0]  load_size,
  input  logic        load_signed,
  input  logic [1:0]  addr_lo,
  output logic [31:0] load_value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = load_data[7:0];
    case (addr_lo)
      2'd0: byte_lane = load_data[7:0];
      2'd1: byte_lane = load_data[15:8];
      2'd2: byte_lane = load_data[23:16];
      2'd3: byte_lane = load_data[31:24];
      default: byte_lane = load_data[7:0];
    endcase

    // addr_lo[0] is ignored for halves; misaligned halves never reach here
    half_lane = addr_lo[1] ? load_data[31:16] : load_data[15:0];

    case (load_size)
      LOAD_BYTE: load_value = {{24{load_signed & byte_lane[7]}}, byte_lane};
      LOAD_HALF: load_value = {{16{load_signed & half_lane[15]}}, half_lane};
      LOAD_WORD: load_value = load_data;
      default:   load_value = load_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Arbitrates MEM results and mul/div results onto the register-file write port; MEM always wins.
// Latency 1 cycle (registered outputs); md side uses valid/ready with a 1-entry skid, md_ready low while the skid is full.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_is_load,
  input  logic [31:0]       load_data,
  input  logic [1:0]        load_size,
  input  logic              load_signed,
  input  logic [1:0]        addr_lo,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_W-1:0]  md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              write_back_en,
  output logic [REG_W-1:0]  write_back_reg,
  output logic [DATA_W-1:0] write_back,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
);

  skid_state_e       state_q, state_d;
  logic [REG_W-1:0]  skid_reg_q;
  logic [DATA_W-1:0] skid_data_q;

  logic [31:0]       load_value;
  logic [DATA_W-1:0] mem_result;
  logic              md_xfer;
  logic              skid_load;

  logic              sel_vld;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;

  load_align u_load_align (
    .load_data   (load_data),
    .load_size   (load_size),
    .load_signed (load_signed),
    .addr_lo     (addr_lo),
    .load_value  (load_value)
  );

  assign mem_result = mem_is_load ? load_value : mem_data;
  assign md_xfer    = md_valid && md_ready;
  // md_ready already implies an empty skid, so a transfer beside MEM parks there
  assign skid_load  = mem_valid && md_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SKID_EMPTY: if (skid_load) state_d = SKID_FULL;
      SKID_FULL:  if (!mem_valid) state_d = SKID_EMPTY;
      default:    state_d = SKID_EMPTY;
    endcase
  end

  always_comb begin
    md_ready = (state_q == SKID_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_reg_q  <= '0;
      skid_data_q <= '0;
    end else if (skid_load) begin
      skid_reg_q  <= md_reg;
      skid_data_q <= md_data;
    end
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_reg  = mem_reg;
    sel_data = mem_result;
    if (mem_valid) begin
      sel_vld = 1'b1;
    end else if (state_q == SKID_FULL) begin
      sel_vld  = 1'b1;
      sel_reg  = skid_reg_q;
      sel_data = skid_data_q;
    end else if (md_xfer) begin
      sel_vld  = 1'b1;
      sel_reg  = md_reg;
      sel_data = md_data;
    end
  end

  // Writes to r0 are consumed but never enabled; index/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      write_back_en  <= 1'b0;
      write_back_reg <= '0;
      write_back     <= '0;
    end else begin
      write_back_en <= sel_vld && (sel_reg != REG_ZERO);
      if (sel_vld) begin
        write_back_reg <= sel_reg;
        write_back     <= sel_data;
      end
    end
  end

  assign fwd_valid = write_back_en;
  assign fwd_reg   = write_back_reg;
  assign fwd_data  = write_back;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage: expected writes are queued at issue,
// a negedge monitor pops and compares every enabled write.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_is_load;
  logic [31:0] load_data;
  logic [1:0]  load_size;
  logic        load_signed;
  logic [1:0]  addr_lo;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        write_back_en;
  logic [4:0]  write_back_reg;
  logic [31:0] write_back;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;

  writeback_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_reg        (mem_reg),
    .mem_data       (mem_data),
    .mem_is_load    (mem_is_load),
    .load_data      (load_data),
    .load_size      (load_size),
    .load_signed    (load_signed),
    .addr_lo        (addr_lo),
    .md_valid       (md_valid),
    .md_ready       (md_ready),
    .md_reg         (md_reg),
    .md_data        (md_data),
    .write_back_en  (write_back_en),
    .write_back_reg (write_back_reg),
    .write_back     (write_back),
    .fwd_valid      (fwd_valid),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(input logic [4:0] r, input logic [31:0] d);
    mem_valid   = 1'b1;
    mem_reg     = r;
    mem_data    = d;
    mem_is_load = 1'b0;
  endtask

  task automatic drive_md(input logic [4:0] r, input logic [31:0] d);
    md_valid = 1'b1;
    md_reg   = r;
    md_data  = d;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back('{r: r, d: d});
  endtask

  // Scoreboard monitor: every enabled write must match the head of the queue
  always @(negedge clk) begin
    if (write_back_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got reg %0d data %h, required no write",
                 write_back_reg, write_back);
      end else begin
        mon_e = exp_q.pop_front();
        if (write_back_reg !== mon_e.r || write_back !== mon_e.d ||
            fwd_valid !== 1'b1 || fwd_reg !== mon_e.r || fwd_data !== mon_e.d) begin
          n_fail++;
          $display("FAIL scoreboard_write: got reg %0d data %h fwd %b/%0d/%h, required reg %0d data %h",
                   write_back_reg, write_back, fwd_valid, fwd_reg, fwd_data, mon_e.r, mon_e.d);
        end
      end
    end
  end

  logic [1:0]  lv_size [8];
  logic        lv_sgn  [8];
  logic [1:0]  lv_addr [8];
  logic [31:0] lv_exp  [8];

  initial begin
    lv_size = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01};
    lv_sgn  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    lv_addr = '{2'd1,  2'd3,  2'd2,  2'd1,  2'd3,  2'd2,  2'd1,  2'd0};
    lv_exp  = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h8899AABB,
                32'h00008899, 32'hFFFFFF99, 32'h8899AABB, 32'hFFFFAABB};

    rst = 1'b1;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0; mem_is_load = 1'b0;
    load_data = '0; load_size = 2'b10; load_signed = 1'b0; addr_lo = '0;
    md_valid = 1'b0; md_reg = '0; md_data = '0;

    step();
    step();
    rst = 1'b0;
    chk("reset_wb_en", {31'd0, write_back_en}, 32'd0);
    chk("reset_wb_data", write_back, 32'd0);
    chk("reset_wb_reg", {27'd0, write_back_reg}, 32'd0);
    chk("reset_md_ready", {31'd0, md_ready}, 32'd1);
    chk("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);

    // Loads, back to back, one register per vector
    load_data = 32'h8899AABB;
    for (int i = 0; i < 8; i++) begin
      mem_valid   = 1'b1;
      mem_reg     = 5'(i + 1);
      mem_data    = 32'h0BAD0BAD;
      mem_is_load = 1'b1;
      load_size   = lv_size[i];
      load_signed = lv_sgn[i];
      addr_lo     = lv_addr[i];
      expect_wr(5'(i + 1), lv_exp[i]);
      step();
      chk($sformatf("load_%0d_data", i), write_back, lv_exp[i]);
    end
    mem_valid = 1'b0;
    mem_is_load = 1'b0;
    step();
    chk("idle_wb_en", {31'd0, write_back_en}, 32'd0);
    chk("idle_hold_data", write_back, lv_exp[7]);

    // ALU write with timing and forwarding check
    drive_mem(5'd5, 32'h12345678);
    expect_wr(5'd5, 32'h12345678);
    step();
    mem_valid = 1'b0;
    chk("alu_wb_en", {31'd0, write_back_en}, 32'd1);
    chk("alu_wb_reg", {27'd0, write_back_reg}, 32'd5);
    chk("alu_wb_data", write_back, 32'h12345678);
    chk("alu_fwd_data", fwd_data, 32'h12345678);
    step();

    // Collision: MEM wins, md parks in skid
    drive_mem(5'd3, 32'h11);
    drive_md(5'd7, 32'h22);
    expect_wr(5'd3, 32'h11);
    expect_wr(5'd7, 32'h22);
    step();
    mem_valid = 1'b0;
    md_valid  = 1'b0;
    chk("coll_n1_reg", {27'd0, write_back_reg}, 32'd3);
    chk("coll_n1_md_ready", {31'd0, md_ready}, 32'd0);
    step();
    chk("coll_n2_reg", {27'd0, write_back_reg}, 32'd7);
    chk("coll_n2_data", write_back, 32'h22);
    step();
    chk("coll_n3_md_ready", {31'd0, md_ready}, 32'd1);
    chk("coll_n3_wb_en", {31'd0, write_back_en}, 32'd0);

    // Stall: skid full while MEM streams; a second md offer waits
    drive_mem(5'd20, 32'h2000);
    drive_md(5'd9, 32'hAA);
    expect_wr(5'd20, 32'h2000);
    step();
    drive_md(5'd15, 32'h55);
    for (int i = 0; i < 4; i++) begin
      drive_mem(5'(21 + i), 32'h2100 + 32'(i));
      expect_wr(5'(21 + i), 32'h2100 + 32'(i));
      chk($sformatf("stall_md_ready_%0d", i), {31'd0, md_ready}, 32'd0);
      step();
    end
    mem_valid = 1'b0;
    chk("stall_end_md_ready", {31'd0, md_ready}, 32'd0);
    expect_wr(5'd9, 32'hAA);
    step();
    chk("drain_reg", {27'd0, write_back_reg}, 32'd9);
    chk("drain_data", write_back, 32'hAA);
    chk("drain_md_ready", {31'd0, md_ready}, 32'd1);
    expect_wr(5'd15, 32'h55);
    step();
    md_valid = 1'b0;
    chk("direct_md_reg", {27'd0, write_back_reg}, 32'd15);
    chk("direct_md_data", write_back, 32'h55);
    step();

    // Register 0 never enables a write
    drive_mem(5'd0, 32'hDEAD);
    step();
    mem_valid = 1'b0;
    chk("r0_mem_wb_en", {31'd0, write_back_en}, 32'd0);
    drive_md(5'd0, 32'h77);
    chk("r0_md_ready", {31'd0, md_ready}, 32'd1);
    step();
    md_valid = 1'b0;
    chk("r0_md_wb_en", {31'd0, write_back_en}, 32'd0);
    chk("r0_md_ready_after", {31'd0, md_ready}, 32'd1);
    step();

    // Reset with skid full discards the parked entry
    drive_mem(5'd4, 32'h44);
    drive_md(5'd12, 32'hCC);
    expect_wr(5'd4, 32'h44);
    step();
    mem_valid = 1'b0;
    md_valid  = 1'b0;
    chk("pre_rst_md_ready", {31'd0, md_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_md_ready", {31'd0, md_ready}, 32'd1);
    chk("rst_mid_wb_en", {31'd0, write_back_en}, 32'd0);
    chk("rst_mid_wb_data", write_back, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_wb_en_%0d", i), {31'd0, write_back_en}, 32'd0);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
